// File: rtl/key_pkg.sv
// Shared key indices and sizes for the mode-select keys, plus the helper that
// picks the lowest-index key from a set of keys.
package key_pkg;

  localparam int unsigned KEY_NUM    = 10;
  localparam int unsigned KEY_CODE_W = 4;

  // Index order matches the display/mode-select consumer's priority order.
  localparam int unsigned KEY_D0 = 0;
  localparam int unsigned KEY_D1 = 1;
  localparam int unsigned KEY_D2 = 2;
  localparam int unsigned KEY_D3 = 3;
  localparam int unsigned KEY_D4 = 4;
  localparam int unsigned KEY_C0 = 5;
  localparam int unsigned KEY_C1 = 6;
  localparam int unsigned KEY_C2 = 7;
  localparam int unsigned KEY_C3 = 8;
  localparam int unsigned KEY_C4 = 9;

  function automatic logic [KEY_CODE_W-1:0] lowest_key(input logic [KEY_NUM-1:0] v);
    lowest_key = '0;
    // Walk downwards so the last hit is the lowest set index.
    for (int unsigned i = KEY_NUM; i > 0; i--) begin
      if (v[i-1]) lowest_key = KEY_CODE_W'(i - 1);
    end
  endfunction

endpackage

// File: rtl/key_debounce_bit.sv
// One key: 2-flop synchroniser, stability counter and registered debounced
// output. Evaluates only on the shared sample tick.
module key_debounce_bit #(
  parameter int unsigned STABLE_CNT = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic tick,
  input  logic raw,
  output logic key
);

  localparam int unsigned    CNT_W    = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync <= '1;
      cnt  <= '0;
      key  <= 1'b1;
    end else begin
      sync <= {sync[0], raw};
      if (tick) begin
        // Any agreeing sample restarts the count; only a full run of
        // disagreeing ticks moves the output.
        if (sync[1] == key) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          key <= sync[1];
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/key_debounce.sv
// Debounces the ten active-low mode-select keys (d0..d4 -> 0..4, c0..c4 -> 5..9).
// Define KEY_EVENT_EN to add the key_event / key_code press encoder.
module key_debounce
  import key_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 50000,
  parameter int unsigned STABLE_CNT = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [4:0]            key_d_raw,
  input  logic [4:0]            key_c_raw,
  output logic [4:0]            key_d,
  output logic [4:0]            key_c
`ifdef KEY_EVENT_EN
  ,
  output logic                  key_event,
  output logic [KEY_CODE_W-1:0] key_code
`endif
);

  localparam int unsigned      PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0]   pre;
  logic               tick;
  logic [KEY_NUM-1:0] raw;
  logic [KEY_NUM-1:0] keys;

  assign tick = (pre == PRE_LAST);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) pre <= '0;
    else      pre <= tick ? '0 : pre + 1'b1;
  end

  assign raw   = {key_c_raw, key_d_raw};
  assign key_d = keys[KEY_D4:KEY_D0];
  assign key_c = keys[KEY_C4:KEY_C0];

  for (genvar i = 0; i < KEY_NUM; i++) begin : g_key
    key_debounce_bit #(
      .STABLE_CNT(STABLE_CNT)
    ) u_bit (
      .CLK  (CLK),
      .RST  (RST),
      .tick (tick),
      .raw  (raw[i]),
      .key  (keys[i])
    );
  end

`ifdef KEY_EVENT_EN
  logic [KEY_NUM-1:0] prev;
  logic [KEY_NUM-1:0] fell;

  // Compare against last cycle's outputs so the pulse lands one cycle after
  // the debounced lines show the press.
  assign fell = prev & ~keys;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      prev      <= '1;
      key_event <= 1'b0;
      key_code  <= '0;
    end else begin
      prev      <= keys;
      key_event <= |fell;
      if (|fell) key_code <= lowest_key(fell);
    end
  end
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench: TICK_DIV=4/STABLE_CNT=3 main instance plus a
// TICK_DIV=1/STABLE_CNT=1 instance for the edge-parameter case.
module tb_key_debounce;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [4:0] d_raw, c_raw, d_out, c_out;
  logic [4:0] d_raw1, c_raw1, d_out1, c_out1;

  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 CLK = ~CLK;

`ifdef KEY_EVENT_EN
  logic       ev0, ev1;
  logic [3:0] code0, code1;
  int         ev_cnt = 0;

  always @(posedge CLK) if (ev0) ev_cnt++;
`endif

  key_debounce #(
    .TICK_DIV   (4),
    .STABLE_CNT (3)
  ) u_dut (
    .CLK       (CLK),
    .RST       (RST),
    .key_d_raw (d_raw),
    .key_c_raw (c_raw),
    .key_d     (d_out),
    .key_c     (c_out)
`ifdef KEY_EVENT_EN
    ,
    .key_event (ev0),
    .key_code  (code0)
`endif
  );

  key_debounce #(
    .TICK_DIV   (1),
    .STABLE_CNT (1)
  ) u_dut1 (
    .CLK       (CLK),
    .RST       (RST),
    .key_d_raw (d_raw1),
    .key_c_raw (c_raw1),
    .key_d     (d_out1),
    .key_c     (c_out1)
`ifdef KEY_EVENT_EN
    ,
    .key_event (ev1),
    .key_code  (code1)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance n active edges and stop on the following falling edge.
  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic wait_change(input logic [9:0] ref_v, output int lat);
    lat = 0;
    while ({c_out, d_out} == ref_v && lat < 40) begin
      step(1);
      lat++;
    end
  endtask

  logic [9:0] vec [8];
  logic [9:0] exp1;
  logic [4:0] acc;
  int         lat;

  initial begin
    vec = '{10'h3FE, 10'h3FD, 10'h000, 10'h3FF, 10'h155, 10'h2AA, 10'h0F0, 10'h30F};
    d_raw  = '0;
    c_raw  = '0;
    d_raw1 = '1;
    c_raw1 = '1;

    // Reset with all keys held low.
    repeat (3) @(negedge CLK);
    check("rst_d", d_out, 5'h1F);
    check("rst_c", c_out, 5'h1F);
`ifdef KEY_EVENT_EN
    check("rst_ev", ev0, 1'b0);
    check("rst_code", code0, 4'd0);
`endif
    RST = 1'b1;
    step(11);
    check("hold_d", d_out, 5'h1F);
    check("hold_c", c_out, 5'h1F);
    step(1);
    check("held_drop_d", d_out, 5'h00);
    check("held_drop_c", c_out, 5'h00);
`ifdef KEY_EVENT_EN
    step(1);
    check("held_ev", ev0, 1'b1);
    check("held_code", code0, 4'd0);
    step(1);
    check("held_ev_end", ev0, 1'b0);
`endif
    d_raw = '1;
    c_raw = '1;
    step(20);
    check("idle_d", d_out, 5'h1F);
    check("idle_c", c_out, 5'h1F);
`ifdef KEY_EVENT_EN
    check("idle_evcnt", ev_cnt, 1);
`endif

    // Clean press of d2.
    d_raw[2] = 1'b0;
    wait_change(10'h3FF, lat);
    check("press_lat_in_range", 32'(lat >= 11 && lat <= 14), 1);
    check("press_d", d_out, 5'b11011);
    check("press_c", c_out, 5'h1F);
`ifdef KEY_EVENT_EN
    step(1);
    check("press_ev", ev0, 1'b1);
    check("press_code", code0, 4'd2);
    step(1);
    check("press_ev_end", ev0, 1'b0);
`endif

    // c0 bounces: low 2 ticks, high 1 tick, five times.
    acc = '1;
    repeat (5) begin
      c_raw[0] = 1'b0;
      repeat (8) begin
        step(1);
        acc &= c_out;
      end
      c_raw[0] = 1'b1;
      repeat (4) begin
        step(1);
        acc &= c_out;
      end
    end
    check("bounce_c", acc, 5'h1F);
`ifdef KEY_EVENT_EN
    check("bounce_evcnt", ev_cnt, 2);
`endif
    c_raw[0] = 1'b0;
    wait_change({5'h1F, 5'b11011}, lat);
    check("bounce_hold_c", c_out, 5'b11110);
    check("bounce_hold_d", d_out, 5'b11011);
`ifdef KEY_EVENT_EN
    step(1);
    check("bounce_code", code0, 4'd5);
`endif

    // Simultaneous press of d4 and c1.
    d_raw[4] = 1'b0;
    c_raw[1] = 1'b0;
    wait_change({5'b11110, 5'b11011}, lat);
    check("simul_d", d_out, 5'b01011);
    check("simul_c", c_out, 5'b11100);
`ifdef KEY_EVENT_EN
    step(1);
    check("simul_code", code0, 4'd4);
    step(2);
    check("simul_evcnt", ev_cnt, 4);
`endif

    // Release all: outputs recover, no event.
    d_raw = '1;
    c_raw = '1;
    step(20);
    check("release_d", d_out, 5'h1F);
    check("release_c", c_out, 5'h1F);
`ifdef KEY_EVENT_EN
    check("release_evcnt", ev_cnt, 4);
`endif

    // Reset two ticks into a press of d0, key held throughout.
    d_raw[0] = 1'b0;
    step(10);
    check("mid_pre_d", d_out, 5'h1F);
    RST = 1'b0;
    step(1);
    check("mid_rst_d", d_out, 5'h1F);
`ifdef KEY_EVENT_EN
    check("mid_rst_ev", ev0, 1'b0);
`endif
    step(2);
    RST = 1'b1;
    step(11);
    check("mid_hold_d", d_out, 5'h1F);
    step(1);
    check("mid_drop_d", d_out, 5'b11110);
`ifdef KEY_EVENT_EN
    step(1);
    check("mid_ev", ev0, 1'b1);
    check("mid_code", code0, 4'd0);
`endif

    // TICK_DIV=1, STABLE_CNT=1: output follows raw three edges later.
    for (int i = 0; i < 10; i++) begin
      if (i < 8) {c_raw1, d_raw1} = vec[i];
      step(1);
      exp1 = (i >= 2) ? vec[i-2] : 10'h3FF;
      check($sformatf("follow_%0d", i), {c_out1, d_out1}, exp1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
